dma_mem_arbiter: RTL and testbench
==================================

Name: dma_mem_arbiter

Overview:
- Arbitrates the single data-memory port between the pipeline MEM stage (CPU) and the DMA channel.
- Bus is parked on the CPU, so a CPU access has zero wait states while DMA is idle.
- DMA gets cycle-stolen bursts when the CPU is idle, or forcibly once a starvation limit is reached.
- The stall output feeds the pipeline hold logic alongside the hazard unit's memHold/pcHold.

Parameters:
- ADDR_W, 32, address width of all address ports.
- DATA_W, 32, data width of all data ports.
- MAX_BURST, 8, maximum DMA beats per grant (1..15).
- STARVE_LIMIT, 4, consecutive blocked DMA cycles before DMA preempts the CPU (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  MEM stage requests the port this cycle.
- cpu_we  in  1  CPU write enable.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_hold  out  1  CPU access not serviced this cycle; pipeline must freeze.
- dma_req  in  1  DMA channel request (level).
- dma_len  in  4  requested burst beats; sampled at grant.
- dma_we  in  1  DMA write enable.
- dma_addr  in  ADDR_W  DMA beat address.
- dma_wdata  in  DATA_W  DMA write data.
- dma_ack  out  1  a DMA beat is issued to memory this cycle.
- dma_done  out  1  one-cycle pulse on the final beat of a grant.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  muxed address.
- mem_wdata  out  DATA_W  muxed write data.

Behaviour:
- FSM states: CPU (park), DMA, TURN. All state and counters are registered; every output is a combinational decode of the current state plus the current inputs.
- Reset:
  - state = CPU; beat_cnt, burst_len and starve_cnt = 0.
  - Outputs reflect state CPU with no request: cpu_hold, dma_ack, dma_done, mem_en and mem_we all 0; mem_addr/mem_wdata = cpu_addr/cpu_wdata.
  - Reset mid-burst aborts the burst immediately: dma_ack drops asynchronously and no dma_done pulse is generated.
- Behaviour in state CPU:
  - mem_* = cpu_*; mem_en = cpu_req; cpu_hold = 0; dma_ack = 0.
  - starve_cnt increments (saturating at STARVE_LIMIT) on each cycle with dma_req && cpu_req, and clears when dma_req = 0.
  - Next state is DMA if dma_req && (!cpu_req || starve_cnt == STARVE_LIMIT); otherwise stay in CPU.
  - The CPU access in the transition cycle still completes.
  - On entering DMA: burst_len = dma_len, clamped to MAX_BURST, with 0 treated as 1; beat_cnt = 0; starve_cnt = 0.
- Behaviour in state DMA:
  - mem_* = dma_*; mem_en = dma_req; dma_ack = dma_req; cpu_hold = cpu_req.
  - beat_cnt increments on each acked beat.
  - dma_done = dma_ack && (beat_cnt == burst_len-1).
  - Next state is TURN on the last beat, or when dma_req = 0 (early release, no dma_done).
- Behaviour in state TURN:
  - Dead cycle for bus turnaround: mem_en = 0, dma_ack = 0, cpu_hold = cpu_req.
  - Next state is always CPU. DMA cannot be regranted directly from TURN.
- Latency:
  - CPU access: 0 wait states in CPU state.
  - DMA first beat: 1 cycle after grant decision.
  - Worst-case DMA wait with a continuously busy CPU: STARVE_LIMIT+1 cycles.
  - Worst-case CPU stall: burst_len + 1 cycles (the +1 is TURN).
- Simultaneous events:
  - A new dma_req in the same cycle as the last beat is ignored until CPU state.
  - cpu_req and dma_req both arriving in CPU state with starve_cnt < limit: CPU wins.
- mem_we is forced to 0 whenever mem_en = 0.

Test Plan:
- Reset with cpu_req = 1 → cpu_hold = 0, mem_en = 1, state CPU; assert rst → dma_ack = dma_done = 0 immediately.
- CPU idle; dma_req = 1, dma_len = 3 → dma_ack high for 3 cycles starting cycle+1; dma_done on the 3rd beat; 1 TURN cycle with mem_en = 0; then CPU.
- cpu_req and dma_req held high continuously, STARVE_LIMIT = 4 → DMA granted after 5 CPU cycles; cpu_hold = 1 for burst_len + 1 cycles; starve_cnt back to 0.
- dma_len = 0 → exactly 1 beat with dma_done; dma_len = 12 with MAX_BURST = 8 → 8 beats then TURN.
- dma_req dropped after beat 2 of 5 → no dma_done; TURN next cycle; CPU access resumes with 0 wait states.
- rst pulsed during beat 2 of a 4-beat burst → outputs return to reset values asynchronously; after release, a CPU request is served in the same cycle.

Source files
------------

// File: rtl/dma_mem_arbiter_if.sv
// Bundle of CPU, DMA and memory-port signals shared by the arbiter and its neighbours.
// slave is the arbiter's view; master is the view of whoever drives the requests.
interface dma_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_hold;
  logic              dma_req;
  logic [3:0]        dma_len;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_ack;
  logic              dma_done;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_len, dma_we, dma_addr, dma_wdata,
    output cpu_hold, dma_ack, dma_done,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_len, dma_we, dma_addr, dma_wdata,
    input  cpu_hold, dma_ack, dma_done,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dma_mem_arbiter.sv
// Data-memory port arbiter: bus parked on the CPU, DMA gets bursts when the CPU is
// idle or after a starvation limit; every burst ends with one turnaround cycle.
module dma_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_BURST    = 8,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst,
  dma_mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_CPU  = 2'd0,
    S_DMA  = 2'd1,
    S_TURN = 2'd2
  } state_t;

  localparam logic [3:0] MAX_B    = 4'(MAX_BURST);
  localparam logic [3:0] STARVE_L = 4'(STARVE_LIMIT);

  state_t            state, state_nxt;
  logic [3:0]        beat_cnt, burst_len, starve_cnt;
  logic              last_beat, starved;
  logic              mem_en_c, sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // A zero-length request still moves one beat; over-long ones are cut to MAX_BURST.
  function automatic logic [3:0] clamp_len(input logic [3:0] len);
    if (len == 4'd0) return 4'd1;
    if (len > MAX_B) return MAX_B;
    return len;
  endfunction

  assign last_beat = (beat_cnt == burst_len - 4'd1);
  assign starved   = (starve_cnt == STARVE_L);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_CPU;
      beat_cnt   <= 4'd0;
      burst_len  <= 4'd0;
      starve_cnt <= 4'd0;
    end else begin
      state <= state_nxt;
      case (state)
        S_CPU: begin
          if (state_nxt == S_DMA) begin
            burst_len  <= clamp_len(bus.dma_len);
            beat_cnt   <= 4'd0;
            starve_cnt <= 4'd0;
          end else if (!bus.dma_req) begin
            starve_cnt <= 4'd0;
          end else if (bus.cpu_req && !starved) begin
            starve_cnt <= starve_cnt + 4'd1;
          end
        end
        S_DMA: begin
          if (bus.dma_req) beat_cnt <= beat_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_CPU:   if (bus.dma_req && (!bus.cpu_req || starved)) state_nxt = S_DMA;
      S_DMA:   if (!bus.dma_req || last_beat) state_nxt = S_TURN;
      S_TURN:  state_nxt = S_CPU;
      default: state_nxt = S_CPU;
    endcase
  end

  always_comb begin
    sel_addr     = bus.cpu_addr;
    sel_wdata    = bus.cpu_wdata;
    sel_we       = bus.cpu_we;
    mem_en_c     = 1'b0;
    bus.cpu_hold = 1'b0;
    bus.dma_ack  = 1'b0;
    bus.dma_done = 1'b0;
    case (state)
      S_CPU: begin
        mem_en_c = bus.cpu_req;
      end
      S_DMA: begin
        sel_addr     = bus.dma_addr;
        sel_wdata    = bus.dma_wdata;
        sel_we       = bus.dma_we;
        mem_en_c     = bus.dma_req;
        bus.dma_ack  = bus.dma_req;
        bus.cpu_hold = bus.cpu_req;
        bus.dma_done = bus.dma_req && last_beat;
      end
      S_TURN: begin
        bus.cpu_hold = bus.cpu_req;
      end
      default: ;
    endcase
  end

  // Writes never leak out on cycles where the port is not enabled.
  assign bus.mem_en    = mem_en_c;
  assign bus.mem_we    = mem_en_c & sel_we;
  assign bus.mem_addr  = sel_addr;
  assign bus.mem_wdata = sel_wdata;

endmodule

// File: tb/tb_dma_mem_arbiter.sv
// Directed bench for dma_mem_arbiter: reset, idle-CPU bursts, starvation preemption,
// length clamping, early release and mid-burst reset.
module tb_dma_mem_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  dma_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dma_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_BURST(8), .STARVE_LIMIT(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst           = 1'b1;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 32'h100;
    bus.cpu_wdata = 32'hAAAA;
    bus.dma_req   = 1'b0;
    bus.dma_len   = 4'd0;
    bus.dma_we    = 1'b0;
    bus.dma_addr  = 32'h2000;
    bus.dma_wdata = 32'h5555;

    // Reset state with a CPU request present
    #2;
    chk("rst_hold",  32'(bus.cpu_hold), 32'd0);
    chk("rst_en",    32'(bus.mem_en),   32'd1);
    chk("rst_addr",  bus.mem_addr,      32'h100);
    chk("rst_ack",   32'(bus.dma_ack),  32'd0);
    chk("rst_done",  32'(bus.dma_done), 32'd0);
    chk("rst_we",    32'(bus.mem_we),   32'd0);
    step();
    rst = 1'b0;

    // Idle CPU, 3-beat burst
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b1;
    bus.dma_len = 4'd3;
    bus.dma_we  = 1'b1;
    #1;
    chk("b3_grant_en",  32'(bus.mem_en),  32'd0);
    chk("b3_grant_ack", 32'(bus.dma_ack), 32'd0);
    step(); #1;
    chk("b3_beat0_ack",  32'(bus.dma_ack),  32'd1);
    chk("b3_beat0_en",   32'(bus.mem_en),   32'd1);
    chk("b3_beat0_we",   32'(bus.mem_we),   32'd1);
    chk("b3_beat0_addr", bus.mem_addr,      32'h2000);
    chk("b3_beat0_done", 32'(bus.dma_done), 32'd0);
    step(); #1;
    chk("b3_beat1_ack",  32'(bus.dma_ack),  32'd1);
    chk("b3_beat1_done", 32'(bus.dma_done), 32'd0);
    step(); #1;
    chk("b3_beat2_ack",  32'(bus.dma_ack),  32'd1);
    chk("b3_beat2_done", 32'(bus.dma_done), 32'd1);
    chk("b3_beat2_data", bus.mem_wdata,     32'h5555);
    step();
    bus.dma_req = 1'b0;
    bus.cpu_req = 1'b1;
    #1;
    chk("b3_turn_en",   32'(bus.mem_en),   32'd0);
    chk("b3_turn_we",   32'(bus.mem_we),   32'd0);
    chk("b3_turn_ack",  32'(bus.dma_ack),  32'd0);
    chk("b3_turn_hold", 32'(bus.cpu_hold), 32'd1);
    step(); #1;
    chk("b3_cpu_hold", 32'(bus.cpu_hold), 32'd0);
    chk("b3_cpu_en",   32'(bus.mem_en),   32'd1);
    chk("b3_cpu_addr", bus.mem_addr,      32'h100);

    // Continuous CPU + DMA traffic: DMA waits five CPU cycles, then a 2-beat burst
    bus.dma_req = 1'b1;
    bus.dma_len = 4'd2;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("st_cpu%0d_hold", i), 32'(bus.cpu_hold), 32'd0);
      chk($sformatf("st_cpu%0d_ack", i),  32'(bus.dma_ack),  32'd0);
      step();
    end
    #1;
    chk("st_b0_ack",  32'(bus.dma_ack),  32'd1);
    chk("st_b0_hold", 32'(bus.cpu_hold), 32'd1);
    step(); #1;
    chk("st_b1_ack",  32'(bus.dma_ack),  32'd1);
    chk("st_b1_done", 32'(bus.dma_done), 32'd1);
    chk("st_b1_hold", 32'(bus.cpu_hold), 32'd1);
    step(); #1;
    chk("st_turn_hold", 32'(bus.cpu_hold), 32'd1);
    chk("st_turn_ack",  32'(bus.dma_ack),  32'd0);
    step();
    // Starvation counter restarted from zero: another five CPU cycles first
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("st2_cpu%0d_hold", i), 32'(bus.cpu_hold), 32'd0);
      chk($sformatf("st2_cpu%0d_ack", i),  32'(bus.dma_ack),  32'd0);
      step();
    end
    #1;
    chk("st2_b0_ack", 32'(bus.dma_ack), 32'd1);
    step();
    bus.dma_req = 1'b0;
    #1;
    chk("st2_rel_ack",  32'(bus.dma_ack),  32'd0);
    chk("st2_rel_done", 32'(bus.dma_done), 32'd0);
    chk("st2_rel_hold", 32'(bus.cpu_hold), 32'd1);
    step(); #1;
    chk("st2_turn_hold", 32'(bus.cpu_hold), 32'd1);
    step(); #1;
    chk("st2_cpu_hold", 32'(bus.cpu_hold), 32'd0);
    chk("st2_cpu_en",   32'(bus.mem_en),   32'd1);

    // Zero length request moves exactly one beat
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b1;
    bus.dma_len = 4'd0;
    step(); #1;
    chk("z_b0_ack",  32'(bus.dma_ack),  32'd1);
    chk("z_b0_done", 32'(bus.dma_done), 32'd1);
    step();
    bus.dma_req = 1'b0;
    #1;
    chk("z_turn_en", 32'(bus.mem_en), 32'd0);
    step();

    // Length 12 clamps to 8 beats
    bus.dma_req = 1'b1;
    bus.dma_len = 4'd12;
    #1;
    chk("c_grant_ack", 32'(bus.dma_ack), 32'd0);
    step();
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("c_b%0d_ack", i),  32'(bus.dma_ack),  32'd1);
      chk($sformatf("c_b%0d_done", i), 32'(bus.dma_done), (i == 7) ? 32'd1 : 32'd0);
      step();
    end
    #1;
    chk("c_turn_ack", 32'(bus.dma_ack), 32'd0);
    chk("c_turn_en",  32'(bus.mem_en),  32'd0);
    bus.dma_req = 1'b0;
    step();

    // Early release after two beats of a five-beat burst
    bus.dma_req = 1'b1;
    bus.dma_len = 4'd5;
    step(); #1;
    chk("e_b0_ack", 32'(bus.dma_ack), 32'd1);
    step(); #1;
    chk("e_b1_ack",  32'(bus.dma_ack),  32'd1);
    chk("e_b1_done", 32'(bus.dma_done), 32'd0);
    step();
    bus.dma_req = 1'b0;
    #1;
    chk("e_rel_ack",  32'(bus.dma_ack),  32'd0);
    chk("e_rel_done", 32'(bus.dma_done), 32'd0);
    chk("e_rel_en",   32'(bus.mem_en),   32'd0);
    step();
    bus.cpu_req = 1'b1;
    #1;
    chk("e_turn_en",   32'(bus.mem_en),   32'd0);
    chk("e_turn_hold", 32'(bus.cpu_hold), 32'd1);
    step(); #1;
    chk("e_cpu_hold", 32'(bus.cpu_hold), 32'd0);
    chk("e_cpu_en",   32'(bus.mem_en),   32'd1);
    chk("e_cpu_addr", bus.mem_addr,      32'h100);

    // Reset asserted during beat 2 of a four-beat burst
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b1;
    bus.dma_len = 4'd4;
    step(); #1;
    chk("r_b0_ack", 32'(bus.dma_ack), 32'd1);
    step(); #1;
    chk("r_b1_ack", 32'(bus.dma_ack), 32'd1);
    rst = 1'b1;
    #1;
    chk("r_async_ack",  32'(bus.dma_ack),  32'd0);
    chk("r_async_done", 32'(bus.dma_done), 32'd0);
    chk("r_async_en",   32'(bus.mem_en),   32'd0);
    chk("r_async_addr", bus.mem_addr,      32'h100);
    #1;
    rst = 1'b0;
    bus.dma_req  = 1'b0;
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'h300;
    #1;
    chk("r_cpu_hold", 32'(bus.cpu_hold), 32'd0);
    chk("r_cpu_en",   32'(bus.mem_en),   32'd1);
    chk("r_cpu_addr", bus.mem_addr,      32'h300);
    step(); #1;
    chk("r_cpu2_hold", 32'(bus.cpu_hold), 32'd0);
    chk("r_cpu2_ack",  32'(bus.dma_ack),  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
